// File: rtl/expr_pkg.sv
// Shared definitions for the expression-evaluation controller.
//   state_t    : controller states (3-bit encoding)
//   cls_t      : character classes seen by the grammar
//   acc_cmd_t  : commands the controller issues to the accumulator
//   CH_*       : ASCII constants used by the grammar
//   char_class : maps an ASCII byte to its class
package expr_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPND = 3'd1,
    OPER = 3'd2,
    ERR  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_DIG = 2'd0,
    CLS_OP  = 2'd1,
    CLS_EQ  = 2'd2,
    CLS_BAD = 2'd3
  } cls_t;

  typedef enum logic [2:0] {
    ACC_HOLD  = 3'd0,
    ACC_LOAD  = 3'd1,
    ACC_MUL   = 3'd2,
    ACC_ADDLD = 3'd3,
    ACC_CLEAR = 3'd4
  } acc_cmd_t;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_EQ  = 8'h3D;

  function automatic cls_t char_class(input logic [7:0] c);
    cls_t cls;
    if (c >= CH_0 && c <= CH_9)
      cls = CLS_DIG;
    else if (c == CH_ADD || c == CH_MUL)
      cls = CLS_OP;
    else if (c == CH_EQ)
      cls = CLS_EQ;
    else
      cls = CLS_BAD;
    return cls;
  endfunction

endpackage

// File: rtl/expr_acc.sv
// Sum/product accumulator for precedence-correct evaluation of digit
// expressions. prod holds the running '*' term, sum the completed '+' terms.
// Ports:
//   clk, clr : clock, asynchronous active-high reset
//   cmd      : HOLD / LOAD (prod<=d, sum<=0) / MUL (prod<=prod*d) /
//              ADDLD (sum<=sum+prod, prod<=d) / CLEAR
//   d        : digit value 0..9, zero-extended to W
//   sum,prod : accumulator state
//   total    : sum+prod, the value of the expression so far
module expr_acc
  import expr_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  acc_cmd_t     cmd,
  input  logic [3:0]   d,
  output logic [W-1:0] sum,
  output logic [W-1:0] prod,
  output logic [W-1:0] total
);

  logic [W-1:0] dz;

  assign dz    = W'(d);
  assign total = sum + prod;

  // All arithmetic wraps modulo 2^W.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum  <= '0;
      prod <= '0;
    end else begin
      unique case (cmd)
        ACC_LOAD: begin
          sum  <= '0;
          prod <= dz;
        end
        ACC_MUL: prod <= prod * dz;
        ACC_ADDLD: begin
          sum  <= sum + prod;
          prod <= dz;
        end
        ACC_CLEAR: begin
          sum  <= '0;
          prod <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/expr_eval_ctrl.sv
// Validates an ASCII stream against: digit (op digit)* '=' with op in
// {'+','*'}, evaluating it with '*' binding tighter than '+'. One expression
// is in flight; the result is held until the consumer handshakes.
// Ports:
//   clk, clr            : clock, asynchronous active-high reset
//   in_valid, in_char   : character source; in_ready = state != DONE
//   res_valid, res_ready: result handshake (res_valid = state == DONE)
//   res_ok              : 1 = valid syntax, 0 = syntax error
//   result              : evaluated value, 0 on error
//   busy                : expression partially received (OPND/OPER/ERR)
module expr_eval_ctrl
  import expr_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in_char,
  output logic         in_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_ok,
  output logic [W-1:0] result,
  output logic         busy
);

  state_t       state, state_nx;
  acc_cmd_t     cmd;
  cls_t         cls;
  logic         accept;
  logic         lastop_mul;
  logic [7:0]   dchar;
  logic [3:0]   d;
  logic [W-1:0] sum, prod, total;

  assign cls       = char_class(in_char);
  assign dchar     = in_char - CH_0;
  assign d         = dchar[3:0];
  assign in_ready  = (state != DONE);
  assign res_valid = (state == DONE);
  assign busy      = (state == OPND) || (state == OPER) || (state == ERR);
  assign accept    = in_valid && in_ready;

  expr_acc #(.W(W)) u_acc (
    .clk   (clk),
    .clr   (clr),
    .cmd   (cmd),
    .d     (d),
    .sum   (sum),
    .prod  (prod),
    .total (total)
  );

  always_comb begin
    state_nx = state;
    cmd      = ACC_HOLD;
    unique case (state)
      IDLE: if (accept) begin
        if (cls == CLS_DIG) begin
          state_nx = OPND;
          cmd      = ACC_LOAD;
        end else if (cls == CLS_EQ) begin
          state_nx = DONE;
        end else begin
          state_nx = ERR;
        end
      end
      OPND: if (accept) begin
        if (cls == CLS_OP)      state_nx = OPER;
        else if (cls == CLS_EQ) state_nx = DONE;
        else                    state_nx = ERR;
      end
      OPER: if (accept) begin
        if (cls == CLS_DIG) begin
          state_nx = OPND;
          cmd      = lastop_mul ? ACC_MUL : ACC_ADDLD;
        end else begin
          // '=' right after an operator is an error but does not terminate.
          state_nx = ERR;
        end
      end
      ERR: if (accept && cls == CLS_EQ) state_nx = DONE;
      DONE: if (res_ready) begin
        state_nx = IDLE;
        cmd      = ACC_CLEAR;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      lastop_mul <= 1'b0;
      res_ok     <= 1'b0;
      result     <= '0;
    end else begin
      state <= state_nx;
      if (accept && state == OPND && cls == CLS_OP)
        lastop_mul <= (in_char == CH_MUL);
      // Any terminating '=' (IDLE, OPND, ERR) latches the status; only a
      // digit-terminated expression yields a value.
      if (accept && cls == CLS_EQ && state != OPER) begin
        res_ok <= (state == OPND);
        result <= (state == OPND) ? total : '0;
      end
      if (state == DONE && res_ready) begin
        res_ok <= 1'b0;
        result <= '0;
      end
    end
  end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
module tb_expr_eval_ctrl;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        res_valid;
  logic        res_ready;
  logic        res_ok;
  logic [31:0] result;
  logic        busy;

  logic        in_valid8;
  logic [7:0]  in_char8;
  logic        in_ready8;
  logic        res_valid8;
  logic        res_ready8;
  logic        res_ok8;
  logic [7:0]  result8;
  logic        busy8;

  int checks;
  int errors;

  expr_eval_ctrl #(.W(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ok    (res_ok),
    .result    (result),
    .busy      (busy)
  );

  expr_eval_ctrl #(.W(8)) dut8 (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid8),
    .in_char   (in_char8),
    .in_ready  (in_ready8),
    .res_valid (res_valid8),
    .res_ready (res_ready8),
    .res_ok    (res_ok8),
    .result    (result8),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; presents c and returns at the falling edge
  // after the rising edge that accepted it. stalls = cycles with in_ready=0.
  task automatic send(input logic [7:0] c, output int stalls);
    in_valid = 1'b1;
    in_char  = c;
    stalls   = 0;
    while (!in_ready && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout char=%h in_ready=%b required 1", c, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    int st;
    for (int i = 0; i < s.len(); i++) send(s[i], st);
  endtask

  task automatic send8(input logic [7:0] c);
    int n;
    in_valid8 = 1'b1;
    in_char8  = c;
    n = 0;
    while (!in_ready8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready8) begin
      errors++;
      $display("FAIL send8_timeout char=%h in_ready=%b required 1", c, in_ready8);
    end
    @(negedge clk);
  endtask

  task automatic expect_result(input string name, input logic ok, input logic [31:0] val);
    checks++;
    if (res_valid !== 1'b1 || res_ok !== ok || result !== val) begin
      errors++;
      $display("FAIL %s got valid=%b ok=%b result=%0d required valid=1 ok=%b result=%0d",
               name, res_valid, res_ok, result, ok, val);
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_ok !== 1'b0 ||
        result !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b ok=%b res=%0d busy=%b required 1 0 0 0 0",
               in_ready, res_valid, res_ok, result, busy);
    end
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int st;
    send("1", st);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b required 1", busy);
    end
    send_str("+2*3=");
    in_valid = 1'b0;
    expect_result("basic_1+2*3", 1'b1, 32'd7);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_flags got rdy=%b busy=%b required 0 0", in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL basic_after_hs got rdy=%b vld=%b res=%0d required 1 0 0",
               in_ready, res_valid, result);
    end
  endtask

  task automatic test_back_to_back;
    int st;
    send_str("9*9*9+1=");
    expect_result("b2b_730", 1'b1, 32'd730);
    send("0", st);
    checks++;
    if (st !== 1) begin
      errors++;
      $display("FAIL b2b_stall got %0d required 1", st);
    end
    send_str("*5+4=");
    expect_result("b2b_4", 1'b1, 32'd4);
    send("1", st);
    checks++;
    if (st !== 1) begin
      errors++;
      $display("FAIL b2b_stall2 got %0d required 1", st);
    end
    send("=", st);
    expect_result("b2b_1", 1'b1, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_errors;
    int st;
    send_str("12");
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL err_busy got %b required 1", busy);
    end
    send_str("+3=");
    in_valid = 1'b0;
    expect_result("err_12+3", 1'b0, 32'd0);
    @(negedge clk);
    send("=", st);
    in_valid = 1'b0;
    expect_result("err_eq_alone", 1'b0, 32'd0);
    @(negedge clk);
    send_str("4+a=");
    in_valid = 1'b0;
    expect_result("err_4+a", 1'b0, 32'd0);
    @(negedge clk);
    send_str("1+=");
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_eq_after_op got vld=%b busy=%b required 0 1", res_valid, busy);
    end
    send("=", st);
    in_valid = 1'b0;
    expect_result("err_second_eq", 1'b0, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_width8;
    string s;
    s = "9*9*9*9=";
    for (int i = 0; i < s.len(); i++) send8(s[i]);
    in_valid8 = 1'b0;
    checks++;
    if (res_valid8 !== 1'b1 || res_ok8 !== 1'b1 || result8 !== 8'd161) begin
      errors++;
      $display("FAIL width8 got vld=%b ok=%b result=%0d required 1 1 161",
               res_valid8, res_ok8, result8);
    end
    @(negedge clk);
    checks++;
    if (res_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL width8_hs got vld=%b rdy=%b required 0 1", res_valid8, in_ready8);
    end
  endtask

  task automatic test_hold;
    int st;
    res_ready = 1'b0;
    send_str("2+2=");
    in_char = "5";
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || res_valid !== 1'b1 || result !== 32'd4 || res_ok !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d got rdy=%b vld=%b ok=%b res=%0d required 0 1 1 4",
                 i, in_ready, res_valid, res_ok, result);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got rdy=%b vld=%b busy=%b required 1 0 0",
               in_ready, res_valid, busy);
    end
    send("5", st);
    send("=", st);
    in_valid = 1'b0;
    expect_result("hold_next_5", 1'b1, 32'd5);
    @(negedge clk);
  endtask

  task automatic test_clr;
    int st;
    send_str("3*4");
    in_valid = 1'b0;
    #2 clr = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_ok !== 1'b0 ||
        result !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_async got rdy=%b vld=%b ok=%b res=%0d busy=%b required 1 0 0 0 0",
               in_ready, res_valid, res_ok, result, busy);
    end
    @(negedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_after got busy=%b rdy=%b required 0 1", busy, in_ready);
    end
    send_str("5=");
    in_valid = 1'b0;
    expect_result("clr_then_5", 1'b1, 32'd5);
    @(negedge clk);
    res_ready = 1'b0;
    send_str("7=");
    in_valid = 1'b0;
    expect_result("clr_done_pre", 1'b1, 32'd7);
    #2 clr = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_in_done got vld=%b res=%0d rdy=%b required 0 0 1",
               res_valid, result, in_ready);
    end
    @(negedge clk);
    #2 clr = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    clr        = 1'b1;
    in_valid   = 1'b0;
    in_char    = 8'h00;
    res_ready  = 1'b1;
    in_valid8  = 1'b0;
    in_char8   = 8'h00;
    res_ready8 = 1'b1;
    test_reset;
    test_basic;
    test_back_to_back;
    test_errors;
    test_width8;
    test_hold;
    test_clr;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
